row_window_buffer: RTL

- Parametrised successor to the fixed 4-row x 16-byte block buffers.
- ROWS rows of ROW_BYTES bytes. Written WR_BYTES at a time at an arbitrary byte address, with optional byte reversal.
- Tracks per-byte fill state and supports shift-up row rotation with a cleared refill row.
- Presents a wrap-around column window of RD_BYTES bytes from every row. Feeds the round datapath with sliding 4x4 (or wider) state windows.

---
 rtl/row_window_buffer.sv | 91 +++++++++
 1 files changed

// File: rtl/row_window_buffer.sv
// Multi-row byte buffer: byte-addressed word writes, per-byte fill tracking,
// shift-up row rotation and a wrap-around column window read from every row.
module row_window_buffer #(
  parameter int ROWS      = 4,
  parameter int ROW_BYTES = 16,
  parameter int WR_BYTES  = 4,
  parameter int RD_BYTES  = 4,
  parameter bit BYTE_SWAP = 1'b1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int BW = $clog2(ROW_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [RW-1:0]              wr_row,
  input  logic [BW-1:0]              wr_byte,
  input  logic [8*WR_BYTES-1:0]      wr_data,
  input  logic                       shift_up,
  input  logic [BW-1:0]              rd_byte,
  output logic [8*RD_BYTES*ROWS-1:0] rd_data,
  output logic [ROWS-1:0]            row_full,
  output logic                       all_full,
  output logic                       wr_err,
  output logic [15:0]                shift_cnt
);

  logic [ROWS-1:0][ROW_BYTES-1:0][7:0] mem, mem_nx;
  logic [ROWS-1:0][ROW_BYTES-1:0]      mask, mask_nx;
  logic [BW:0]                         pos;
  logic                                ovr;

  // Shift is resolved first so the write lands on the post-shift rows.
  always_comb begin
    mem_nx  = mem;
    mask_nx = mask;
    ovr     = 1'b0;
    pos     = '0;
    if (shift_up) begin
      for (int r = 0; r < ROWS-1; r++) begin
        mem_nx[r]  = mem[r+1];
        mask_nx[r] = mask[r+1];
      end
      mem_nx[ROWS-1]  = '0;
      mask_nx[ROWS-1] = '0;
    end
    if (wr_en) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        pos = {1'b0, wr_byte} + (BW+1)'(i);
        // ROW_BYTES is a power of two, so the carry bit flags a byte past the row end.
        if (pos[BW]) begin
          ovr = 1'b1;
        end else begin
          mem_nx[wr_row][pos[BW-1:0]]  = BYTE_SWAP ? wr_data[8*(WR_BYTES-1-i) +: 8]
                                                   : wr_data[8*i +: 8];
          mask_nx[wr_row][pos[BW-1:0]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem       <= '0;
      mask      <= '0;
      wr_err    <= 1'b0;
      shift_cnt <= '0;
    end else begin
      mem       <= mem_nx;
      mask      <= mask_nx;
      wr_err    <= ovr;
      shift_cnt <= shift_cnt + 16'(shift_up);
    end
  end

  genvar j, r;
  generate
    for (j = 0; j < RD_BYTES; j++) begin : g_col
      logic [BW-1:0] idx;
      assign idx = rd_byte + BW'(j);
      for (r = 0; r < ROWS; r++) begin : g_row
        assign rd_data[8*RD_BYTES*r + 8*j +: 8] = mem[r][idx];
      end
    end
    for (r = 0; r < ROWS; r++) begin : g_full
      assign row_full[r] = &mask[r];
    end
  endgenerate

  assign all_full = &row_full;

endmodule
